// File: rtl/game_pkg.sv
// Shared game definitions: stat-update FSM states, score/lives limits and
// fruit bit positions used by the stats datapath.
`timescale 1ns/1ps
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2
    } upd_state_t;

    localparam int unsigned WIN_SCORE_DEF = 520;
    localparam int unsigned MAX_LIVES_DEF = 3;
    localparam int unsigned SCORE_MAX_DEF = 1023;

    localparam int unsigned FRUIT_APPLE  = 0;
    localparam int unsigned FRUIT_PEAS   = 1;
    localparam int unsigned FRUIT_GRAPES = 2;
    localparam int unsigned FRUIT_DRINK  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending requester at or after i_rr,
// returned both one-hot and as an index.
`timescale 1ns/1ps
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0] i_rr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((32'(i_rr) + k) % N_REQ);
            if (!o_valid && i_pending[w_cand]) begin
                o_valid          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/score_update_arbiter.sv
// Arbitrates game-event requests onto the shared score/fruit/lives registers,
// one read-modify-write per grant, and raises win/lose threshold pulses.
`timescale 1ns/1ps
module score_update_arbiter
    import game_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned SCORE_W   = 10,
    parameter int unsigned SCORE_MAX = SCORE_MAX_DEF,
    parameter int unsigned WIN_SCORE = WIN_SCORE_DEF,
    parameter int unsigned MAX_LIVES = MAX_LIVES_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       clear,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*SCORE_W-1:0]   req_pts,
    input  logic [N_REQ*4-1:0]         req_fruit,
    input  logic [N_REQ-1:0]           req_life,
    output logic [N_REQ-1:0]           req_drop,
    output logic [N_REQ-1:0]           grant,
    input  logic [SCORE_W-1:0]         score_from_reg,
    input  logic [3:0]                 fruits_from_reg,
    input  logic [1:0]                 lives_from_reg,
    output logic [SCORE_W-1:0]         score_to_reg,
    output logic [3:0]                 fruits_to_reg,
    output logic [1:0]                 lives_to_reg,
    output logic                       Load_S,
    output logic                       Load_F,
    output logic                       Load_L,
    output logic                       win_evt,
    output logic                       lose_evt,
    output logic                       busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [SCORE_W:0]   LP_SMAX_W = (SCORE_W+1)'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] LP_SMAX   = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] LP_WIN    = SCORE_W'(WIN_SCORE);
    localparam logic [2:0]         LP_LMAX_W = 3'(MAX_LIVES);
    localparam logic [1:0]         LP_LMAX   = 2'(MAX_LIVES);

    upd_state_t r_state, w_state_nxt;

    logic [N_REQ-1:0]   r_pending;
    logic [SCORE_W-1:0] r_pts   [N_REQ];
    logic [3:0]         r_fruit [N_REQ];
    logic [N_REQ-1:0]   r_life;
    logic [IDX_W-1:0]   r_rr;

    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_drop;
    logic [SCORE_W-1:0] r_score;
    logic [3:0]         r_fruits;
    logic [1:0]         r_lives;
    logic               r_ld_s, r_ld_f, r_ld_l;
    logic               r_win, r_lose;

    logic [N_REQ-1:0]   w_onehot;
    logic [IDX_W-1:0]   w_idx;
    logic               w_valid;
    logic               w_take;
    logic [N_REQ-1:0]   w_clr_mask;
    logic [N_REQ-1:0]   w_accept;
    logic [SCORE_W-1:0] w_pts;
    logic [3:0]         w_fruit;
    logic               w_life;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_new_score;
    logic [2:0]         w_lives_inc;
    logic [1:0]         w_new_lives;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_pending (r_pending),
        .i_rr      (r_rr),
        .o_onehot  (w_onehot),
        .o_idx     (w_idx),
        .o_valid   (w_valid)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_take      = 1'b0;
        end
    end

    // A grant clearing pending[i] in the same cycle as a new req[i] still accepts it.
    assign w_clr_mask = w_take ? w_onehot : '0;
    assign w_accept   = req & (~r_pending | w_clr_mask);

    assign w_pts   = r_pts[w_idx];
    assign w_fruit = r_fruit[w_idx];
    assign w_life  = r_life[w_idx];

    assign w_sum       = {1'b0, score_from_reg} + {1'b0, w_pts};
    assign w_new_score = (w_sum > LP_SMAX_W) ? LP_SMAX : w_sum[SCORE_W-1:0];
    assign w_lives_inc = {1'b0, lives_from_reg} + 3'd1;
    assign w_new_lives = (w_lives_inc > LP_LMAX_W) ? LP_LMAX : w_lives_inc[1:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pending <= '0;
            r_life    <= '0;
            r_rr      <= '0;
            r_drop    <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_pts[i]   <= '0;
                r_fruit[i] <= '0;
            end
        end else if (clear) begin
            r_pending <= '0;
            r_rr      <= '0;
            r_drop    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | req;
            r_drop    <= req & ~w_accept;
            if (w_take)
                r_rr <= (w_idx == IDX_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_pts[i]   <= req_pts[i*SCORE_W +: SCORE_W];
                    r_fruit[i] <= req_fruit[i*4 +: 4];
                    r_life[i]  <= req_life[i];
                end
            end
        end
    end

    // Outputs hold their values only for the single WRITE cycle; zero otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_grant  <= '0;
            r_score  <= '0;
            r_fruits <= '0;
            r_lives  <= '0;
            r_ld_s   <= 1'b0;
            r_ld_f   <= 1'b0;
            r_ld_l   <= 1'b0;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
        end else if (w_take) begin
            r_grant  <= w_onehot;
            r_score  <= w_new_score;
            r_fruits <= fruits_from_reg | w_fruit;
            r_lives  <= w_new_lives;
            r_ld_s   <= (w_pts != '0);
            r_ld_f   <= (w_fruit != 4'b0000);
            r_ld_l   <= w_life;
            r_win    <= (score_from_reg < LP_WIN) && (w_new_score >= LP_WIN);
            r_lose   <= w_life && (lives_from_reg < LP_LMAX) && (w_new_lives == LP_LMAX);
        end else begin
            r_grant  <= '0;
            r_score  <= '0;
            r_fruits <= '0;
            r_lives  <= '0;
            r_ld_s   <= 1'b0;
            r_ld_f   <= 1'b0;
            r_ld_l   <= 1'b0;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
        end
    end

    assign grant         = r_grant;
    assign req_drop      = r_drop;
    assign score_to_reg  = r_score;
    assign fruits_to_reg = r_fruits;
    assign lives_to_reg  = r_lives;
    assign Load_S        = r_ld_s;
    assign Load_F        = r_ld_f;
    assign Load_L        = r_ld_l;
    assign win_evt       = r_win;
    assign lose_evt      = r_lose;
    assign busy          = (r_state != ST_IDLE) || (|r_pending);

endmodule

// File: tb/tb_score_update_arbiter.sv
// Directed bench for score_update_arbiter: hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_score_update_arbiter;

    localparam int N  = 4;
    localparam int SW = 10;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            clear = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*SW-1:0] req_pts = '0;
    logic [N*4-1:0]  req_fruit = '0;
    logic [N-1:0]    req_life = '0;
    logic [N-1:0]    req_drop;
    logic [N-1:0]    grant;
    logic [SW-1:0]   score_from_reg = '0;
    logic [3:0]      fruits_from_reg = '0;
    logic [1:0]      lives_from_reg = '0;
    logic [SW-1:0]   score_to_reg;
    logic [3:0]      fruits_to_reg;
    logic [1:0]      lives_to_reg;
    logic            Load_S, Load_F, Load_L;
    logic            win_evt, lose_evt, busy;

    int n_err = 0;
    int n_chk = 0;

    score_update_arbiter #(
        .N_REQ     (N),
        .SCORE_W   (SW),
        .SCORE_MAX (1023),
        .WIN_SCORE (520),
        .MAX_LIVES (3)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .clear           (clear),
        .req             (req),
        .req_pts         (req_pts),
        .req_fruit       (req_fruit),
        .req_life        (req_life),
        .req_drop        (req_drop),
        .grant           (grant),
        .score_from_reg  (score_from_reg),
        .fruits_from_reg (fruits_from_reg),
        .lives_from_reg  (lives_from_reg),
        .score_to_reg    (score_to_reg),
        .fruits_to_reg   (fruits_to_reg),
        .lives_to_reg    (lives_to_reg),
        .Load_S          (Load_S),
        .Load_F          (Load_F),
        .Load_L          (Load_L),
        .win_evt         (win_evt),
        .lose_evt        (lose_evt),
        .busy            (busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_payload(input int i, input int pts, input logic [3:0] fr, input logic life);
        req_pts[i*SW +: SW] = SW'(pts);
        req_fruit[i*4 +: 4] = fr;
        req_life[i]         = life;
    endtask

    task automatic zero_payloads();
        for (int i = 0; i < N; i++) set_payload(i, 0, 4'b0000, 1'b0);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic test_reset();
        tick();
        n_chk++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_chk++; if ({Load_S, Load_F, Load_L, win_evt, lose_evt} !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 00000", {Load_S, Load_F, Load_L, win_evt, lose_evt}); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if ({score_to_reg, fruits_to_reg, lives_to_reg, req_drop} !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {score_to_reg, fruits_to_reg, lives_to_reg, req_drop}); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        zero_payloads();
        set_payload(0, 50, 4'b0000, 1'b0);
        score_from_reg = 10'd100;
        pulse(4'b0001);
        n_chk++; if (busy !== 1'b1 || grant !== 4'b0000) begin n_err++; $display("FAIL single_pending: got busy=%b grant=%b expected busy=1 grant=0000", busy, grant); end
        tick();
        n_chk++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b expected 0001", grant); end
        n_chk++; if (Load_S !== 1'b1 || score_to_reg !== 10'd150) begin n_err++; $display("FAIL single_score: got load=%b score=%0d expected load=1 score=150", Load_S, score_to_reg); end
        n_chk++; if (Load_F !== 1'b0 || Load_L !== 1'b0 || win_evt !== 1'b0) begin n_err++; $display("FAIL single_other: got F=%b L=%b win=%b expected 0 0 0", Load_F, Load_L, win_evt); end
        tick();
        n_chk++; if (grant !== 4'b0000 || Load_S !== 1'b0) begin n_err++; $display("FAIL single_settle: got grant=%b load=%b expected 0000 0", grant, Load_S); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_order [4];
        exp_order[0] = 4'b0100; exp_order[1] = 4'b1000;
        exp_order[2] = 4'b0001; exp_order[3] = 4'b0010;
        zero_payloads();
        pulse(4'b0010);
        tick(); tick(); tick();
        pulse(4'b1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (grant !== exp_order[k]) begin n_err++; $display("FAIL rr_grant_%0d: got %b expected %b", k, grant, exp_order[k]); end
            n_chk++; if ({Load_S, Load_F, Load_L} !== 3'b000) begin n_err++; $display("FAIL rr_zero_loads_%0d: got %b expected 000", k, {Load_S, Load_F, Load_L}); end
            tick(); tick();
        end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_win();
        zero_payloads();
        set_payload(2, 50, 4'b0000, 1'b0);
        score_from_reg = 10'd500;
        pulse(4'b0100);
        tick();
        n_chk++; if (score_to_reg !== 10'd550 || win_evt !== 1'b1) begin n_err++; $display("FAIL win_cross: got score=%0d win=%b expected 550 1", score_to_reg, win_evt); end
        tick();
        n_chk++; if (win_evt !== 1'b0) begin n_err++; $display("FAIL win_pulse_width: got %b expected 0", win_evt); end
        tick();
        score_from_reg = 10'd550;
        pulse(4'b0100);
        tick();
        n_chk++; if (score_to_reg !== 10'd600 || win_evt !== 1'b0) begin n_err++; $display("FAIL win_again: got score=%0d win=%b expected 600 0", score_to_reg, win_evt); end
        tick(); tick();
        score_from_reg = 10'd470;
        pulse(4'b0100);
        tick();
        n_chk++; if (score_to_reg !== 10'd520 || win_evt !== 1'b1) begin n_err++; $display("FAIL win_exact: got score=%0d win=%b expected 520 1", score_to_reg, win_evt); end
        tick(); tick();
    endtask

    task automatic test_saturate_lives();
        zero_payloads();
        set_payload(3, 50, 4'b0000, 1'b1);
        score_from_reg = 10'd1000;
        lives_from_reg = 2'd2;
        pulse(4'b1000);
        tick();
        n_chk++; if (score_to_reg !== 10'd1023 || Load_S !== 1'b1) begin n_err++; $display("FAIL sat_score: got score=%0d load=%b expected 1023 1", score_to_reg, Load_S); end
        n_chk++; if (lives_to_reg !== 2'd3 || Load_L !== 1'b1 || lose_evt !== 1'b1) begin n_err++; $display("FAIL lose_cross: got lives=%0d L=%b lose=%b expected 3 1 1", lives_to_reg, Load_L, lose_evt); end
        tick(); tick();
        score_from_reg = 10'd1023;
        lives_from_reg = 2'd3;
        pulse(4'b1000);
        tick();
        n_chk++; if (score_to_reg !== 10'd1023 || win_evt !== 1'b0) begin n_err++; $display("FAIL sat_max: got score=%0d win=%b expected 1023 0", score_to_reg, win_evt); end
        n_chk++; if (lives_to_reg !== 2'd3 || Load_L !== 1'b1 || lose_evt !== 1'b0) begin n_err++; $display("FAIL lives_max: got lives=%0d L=%b lose=%b expected 3 1 0", lives_to_reg, Load_L, lose_evt); end
        tick(); tick();
        lives_from_reg = 2'd0;
    endtask

    task automatic test_drop_fruit();
        zero_payloads();
        set_payload(1, 0, 4'b0100, 1'b0);
        fruits_from_reg = 4'b0001;
        pulse(4'b0011);
        tick();
        n_chk++; if (grant !== 4'b0001) begin n_err++; $display("FAIL drop_first_grant: got %b expected 0001", grant); end
        req = 4'b0010;
        tick();
        req = '0;
        n_chk++; if (req_drop !== 4'b0010) begin n_err++; $display("FAIL drop_pulse: got %b expected 0010", req_drop); end
        tick();
        n_chk++; if (req_drop !== 4'b0000) begin n_err++; $display("FAIL drop_width: got %b expected 0000", req_drop); end
        tick();
        n_chk++; if (grant !== 4'b0010 || fruits_to_reg !== 4'b0101 || Load_F !== 1'b1 || Load_S !== 1'b0) begin n_err++; $display("FAIL fruit_or: got grant=%b fruits=%b F=%b S=%b expected 0010 0101 1 0", grant, fruits_to_reg, Load_F, Load_S); end
        tick(); tick();
        fruits_from_reg = 4'b0000;
    endtask

    task automatic test_set_wins();
        zero_payloads();
        set_payload(1, 7, 4'b0000, 1'b0);
        score_from_reg = 10'd0;
        req = 4'b0010;
        tick();
        tick();
        req = '0;
        n_chk++; if (grant !== 4'b0010) begin n_err++; $display("FAIL setwins_grant1: got %b expected 0010", grant); end
        tick();
        n_chk++; if (req_drop !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL setwins_accept: got drop=%b busy=%b expected 0000 1", req_drop, busy); end
        tick(); tick();
        n_chk++; if (grant !== 4'b0010 || score_to_reg !== 10'd7) begin n_err++; $display("FAIL setwins_grant2: got grant=%b score=%0d expected 0010 7", grant, score_to_reg); end
        tick(); tick();
    endtask

    task automatic test_reset_mid_write();
        zero_payloads();
        set_payload(1, 5, 4'b0010, 1'b1);
        pulse(4'b0010);
        tick();
        n_chk++; if (Load_S !== 1'b1) begin n_err++; $display("FAIL rst_write_pre: got %b expected 1", Load_S); end
        #2 Reset = 1'b1;
        #1;
        n_chk++; if ({grant, Load_S, Load_F, Load_L, score_to_reg} !== '0) begin n_err++; $display("FAIL rst_write_drop: got %h expected 0", {grant, Load_S, Load_F, Load_L, score_to_reg}); end
        Reset = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_write_busy: got %b expected 0", busy); end
    endtask

    task automatic test_clear();
        int bad;
        for (int i = 0; i < N; i++) set_payload(i, 5, 4'b0000, 1'b0);
        pulse(4'b1111);
        tick();
        n_chk++; if (grant !== 4'b0001) begin n_err++; $display("FAIL clear_pre_grant: got %b expected 0001", grant); end
        clear = 1'b1;
        req = 4'b0001;
        tick();
        clear = 1'b0;
        req = '0;
        n_chk++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_err++; $display("FAIL clear_idle: got busy=%b grant=%b expected 0 0000", busy, grant); end
        n_chk++; if ({Load_S, Load_F, Load_L, req_drop} !== '0) begin n_err++; $display("FAIL clear_loads: got %b expected 0", {Load_S, Load_F, Load_L, req_drop}); end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (grant !== 4'b0000 || Load_S !== 1'b0 || req_drop !== 4'b0000) bad++;
        end
        n_chk++; if (bad !== 0) begin n_err++; $display("FAIL clear_no_grants: got %0d active cycles expected 0", bad); end
        pulse(4'b0011);
        tick();
        n_chk++; if (grant !== 4'b0001) begin n_err++; $display("FAIL clear_rr_zero: got %b expected 0001", grant); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_win();
        test_saturate_lives();
        test_drop_fruit();
        test_set_wins();
        test_reset_mid_write();
        test_clear();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/score_update_arbiter.md
# score_update_arbiter

Shares the single score/fruit/lives register set between several game-event requesters: pellet eater, fruit detector, ghost-eaten logic and collision logic. Each request is latched with its payload and granted round-robin. The block then performs one read-modify-write on the registers through the existing `Load_S`/`Load_F`/`Load_L` load strobes. It sits between the event sources and the stats registers, and produces the win/lose event pulses consumed by `game_logic`.

## Interface
Parameters:
- `N_REQ` = 4: number of requesters (2..8).
- `SCORE_W` = 10: score width.
- `SCORE_MAX` = 1023: score saturation value.
- `WIN_SCORE` = 520: win threshold.
- `MAX_LIVES` = 3: lives-lost count that ends the game.

Ports:
- `Clk`  in  1: system clock. One clock domain only.
- `Reset`  in  1: reset, asynchronous and active-high.
- `clear`  in  1: synchronous flush, driven from `game_logic` restart.
- `req`  in  `N_REQ`: per-requester 1-cycle request pulse.
- `req_pts`  in  `N_REQ*SCORE_W`: points to add, slice i belongs to requester i.
- `req_fruit`  in  `N_REQ*4`: fruit bits to set, slice i.
- `req_life`  in  `N_REQ`: request also records one life lost.
- `req_drop`  out  `N_REQ`: pulse when a request is lost (requester already pending).
- `grant`  out  `N_REQ`: one-hot, valid during WRITE.
- `score_from_reg`  in  `SCORE_W`; `fruits_from_reg`  in  4; `lives_from_reg`  in  2.
- `score_to_reg`  out  `SCORE_W`; `fruits_to_reg`  out  4; `lives_to_reg`  out  2.
- `Load_S`, `Load_F`, `Load_L`  out  1: register load strobes.
- `win_evt`, `lose_evt`  out  1: threshold-crossing pulses.
- `busy`  out  1: high when the FSM is not in IDLE or any pending bit is set.

## Operation
- **Request capture:** for each requester, a pending bit plus a payload register (pts, fruit, life).
  - A `req` pulse with pending clear sets pending and latches the payload.
  - A `req` pulse with pending already set is dropped; `req_drop[i]` pulses the next cycle.
  - If `req[i]` arrives on the same cycle pending[i] is cleared by a grant, the new request is accepted: set wins.
- **FSM states:** IDLE, WRITE, SETTLE.
  - IDLE: if any pending bit is set, pick a winner with round-robin starting at pointer `rr`. Clear that pending bit, register all outputs, go to WRITE.
  - WRITE: outputs are valid for exactly this cycle; next state is SETTLE.
  - SETTLE: one cycle so that the `*_from_reg` inputs reflect the write; next state is IDLE.
  - After each grant, `rr` = winner+1 mod `N_REQ`.
- **Output values,** computed from the `*_from_reg` values sampled in IDLE:
  - `score_to_reg` = min(score + pts, `SCORE_MAX`), computed at `SCORE_W`+1 bits. `Load_S` = 1 when pts ≠ 0.
  - `fruits_to_reg` = fruits OR mask. `Load_F` = 1 when mask ≠ 0.
  - `lives_to_reg` = min(lives + 1, `MAX_LIVES`). `Load_L` = `req_life` of the winner.
  - `win_evt` = 1 when old score < `WIN_SCORE` and new score ≥ `WIN_SCORE`.
  - `lose_evt` = 1 when old lives < `MAX_LIVES` and new lives = `MAX_LIVES`.
  - A request with all-zero payload is still granted; all loads stay 0.
- **`clear`:** highest priority. It empties all pending bits, forces IDLE, sets `rr` to 0 and zeroes all outputs the next cycle. A `req` on the same cycle as `clear` is discarded, with no drop pulse.

## Timing
- Reset value is 0 for every output, pending bit, payload register and `rr`. The FSM resets to IDLE.
- Latency:
  - `req` at edge t sets pending at t+1.
  - If the FSM is idle with no other pending requests, the grant and loads are valid in the cycle after edge t+2.
  - The registers update at edge t+3.
- Throughput is one update per 3 cycles. A worst-case requester waits at most 3·(`N_REQ`−1) cycles behind the others.
- `Reset` asserted mid-WRITE drops the outputs to 0 immediately, so the partial load is not performed.

## Structure
- Shared package `game_pkg`: the FSM state enum and the `WIN_SCORE`, `MAX_LIVES` and `SCORE_MAX` defaults. The fruit bit indices also go there: apple 0, peas 1, grapes 2, drink 3.
- One combinational sub-module, `rr_pick`: inputs pending vector and `rr`, outputs one-hot winner and index.

## Test plan
- Single request, pts = 50, score_from_reg = 100 → `Load_S` = 1, `score_to_reg` = 150, `grant` = 0001, three cycles after `req`.
- `req` = 1111 together with `rr` = 2 → grants in order 0100, 1000, 0001, 0010, each spaced 3 cycles apart.
- score_from_reg = 500, pts = 50 → `score_to_reg` = 550 and `win_evt` pulses once. A second +50 → no `win_evt`.
- score_from_reg = 1000, pts = 50 → `score_to_reg` = 1023. lives_from_reg = 2 with `req_life` → `lives_to_reg` = 3, `Load_L` = 1, `lose_evt` = 1.
- Requester 1 re-requests while pending → `req_drop[1]` pulses. Fruit mask 0100 with fruits = 0001 → `fruits_to_reg` = 0101.
- `clear` asserted with 3 pending and FSM in WRITE → next cycle: IDLE, `busy` = 0, all loads 0, no further grants.
